calc_sequencer: RTL and testbench
=================================

// Module: calc_sequencer
// PURPOSE
// - Top-level operation controller of the calculator. It steers operand entry into
//   slider_increment via write_number_select and slider_enable.
// - It launches the ALU with a start/done handshake and latches and range-checks
//   the result.
// - It drives the display source select and the error state. It sits between the
//   synchronized push buttons, slider_increment, the ALU and the display driver.
// PARAMETERS
// - WIDTH          14        operand/result magnitude width (matches number_1/number_2)
// - MAX_VALUE      9999      largest displayable magnitude
// - RES_WIDTH      28        ALU result width, two's complement
// - TIMEOUT_CYCLES 1024      ALU watchdog limit (used only with CALC_SEQ_TIMEOUT_EN)
// PORTS
// - clk                 in   1          system clock, all logic on the rising edge
// - rst_ext             in   1          reset, asynchronous, active-low
// - btn_next            in   1          synchronized level; rising edge = next operand
// - btn_equals          in   1          synchronized level; rising edge = compute
// - btn_clear           in   1          synchronized level; rising edge = clear
// - op_sel              in   2          00 add, 01 sub, 10 mul, 11 div
// - alu_done            in   1          one-cycle pulse: result valid
// - alu_error           in   1          qualified by alu_done (divide by zero)
// - alu_result          in   RES_WIDTH  signed result, qualified by alu_done
// - write_number_select out  1          0 -> number_1, 1 -> number_2
// - slider_enable       out  1          sliders may modify operands
// - clear_numbers       out  1          one-cycle pulse: zero both operands
// - alu_start           out  1          one-cycle launch pulse
// - alu_op              out  2          op_sel latched at launch
// - result              out  WIDTH      result magnitude
// - result_neg          out  1          result sign
// - display_select      out  2          00 number_1, 01 number_2, 10 result, 11 error
// - err_code            out  2          00 none, 01 alu_error, 10 range, 11 timeout
// - busy                out  1          high in START and WAIT
// BEHAVIOUR
// - Edge detect: prev_* registers reset to 1, so a button held through reset does not
//   fire. edge = level & ~prev, acting at the same clock edge. Priority: clear > equals > next.
// - States: ENTER_A (reset state), ENTER_B, START, WAIT, RESULT, ERROR.
// - ENTER_A: next -> ENTER_B; equals ignored.
// - ENTER_B: next -> ENTER_A; equals -> START.
// - START: alu_op <= op_sel; alu_start high for exactly this one cycle; -> WAIT next cycle.
// - WAIT: on alu_done:
//   - alu_error -> ERROR, err 01
//   - |alu_result| > MAX_VALUE -> ERROR, err 10
//   - else latch result/result_neg, -> RESULT
// - WAIT: buttons other than clear are ignored.
// - RESULT: equals -> START (recompute with current operands and op_sel); next -> ENTER_A.
// - ERROR: only clear exits.
// - Clear from any state:
//   - -> ENTER_A; clear_numbers pulses 1 cycle
//   - result, result_neg, err_code <= 0
//   - a clear in WAIT aborts; a later stray alu_done is ignored
// - alu_done outside WAIT is ignored.
// - Outputs per state:
//   - slider_enable = 1 only in ENTER_A and ENTER_B
//   - write_number_select = 1 only in ENTER_B
//   - display_select = 00 in ENTER_A, 01 in ENTER_B, 01 in START and WAIT,
//     10 in RESULT, 11 in ERROR
// - Reset values: state ENTER_A; all outputs 0, except display_select = 00.
// - Magnitude: negate when alu_result is negative; compare at full RES_WIDTH before
//   truncating to WIDTH. -MAX_VALUE is accepted (result_neg = 1).
// CONFIGURATION
// - CALC_SEQ_TIMEOUT_EN defined:
//   - watchdog counter clears on entry to WAIT and counts each WAIT cycle
//   - on reaching TIMEOUT_CYCLES without alu_done -> ERROR, err 11
//   - alu_done on the same cycle as the timeout wins
// - CALC_SEQ_TIMEOUT_EN undefined: no counter; WAIT persists until alu_done or clear.
// TESTING
// - Reset released with btn_next held -> stays ENTER_A; release then press -> ENTER_B,
//   write_number_select = 1.
// - ENTER_B, op_sel = 10, equals -> alu_start high for exactly 1 cycle, alu_op = 10.
//   Done with alu_result = 1234 -> RESULT, result = 1234, display_select = 10.
// - alu_result = -25 -> result = 25, result_neg = 1. alu_result = 10000 -> ERROR,
//   err_code = 10, display_select = 11.
// - alu_done with alu_error = 1 -> ERROR, err 01. Next/equals ignored; clear ->
//   ENTER_A, clear_numbers 1 cycle, err_code = 0.
// - Clear and equals rising on the same cycle in ENTER_B -> ENTER_A, no alu_start.
//   Clear in WAIT, then alu_done -> stays ENTER_A.
// - With CALC_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES = 8 and no alu_done -> ERROR with
//   err 11 after 8 WAIT cycles. Without the macro -> still WAIT after 2000 cycles.

Source files
------------

// File: rtl/calc_sequencer.sv
// calc_sequencer: top-level operation controller of the calculator.
// It steers operand entry, launches the ALU with a start/done handshake, and
// range-checks the returned result. It also selects the display source and
// holds the error state.
// Optional feature: define CALC_SEQ_TIMEOUT_EN to enable the ALU watchdog.
// The watchdog forces ERROR (err 11) after TIMEOUT_CYCLES cycles in WAIT.
// ALU handshake:
//   - alu_start is high for exactly one cycle, in START.
//   - alu_op is valid from that cycle on.
//   - The ALU answers with a one-cycle alu_done pulse.
//   - alu_error and alu_result are only meaningful while alu_done is high.
//   - alu_done is honoured only in WAIT; anywhere else it is dropped.
// state_dbg exposes the FSM encoding: 0 ENTER_A, 1 ENTER_B, 2 START, 3 WAIT,
// 4 RESULT, 5 ERROR.
module calc_sequencer #(
  parameter int WIDTH          = 14,
  parameter int MAX_VALUE      = 9999,
  parameter int RES_WIDTH      = 28,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_ext,
  input  logic                 btn_next,
  input  logic                 btn_equals,
  input  logic                 btn_clear,
  input  logic [1:0]           op_sel,
  input  logic                 alu_done,
  input  logic                 alu_error,
  input  logic [RES_WIDTH-1:0] alu_result,
  output logic                 write_number_select,
  output logic                 slider_enable,
  output logic                 clear_numbers,
  output logic                 alu_start,
  output logic [1:0]           alu_op,
  output logic [WIDTH-1:0]     result,
  output logic                 result_neg,
  output logic [1:0]           display_select,
  output logic [1:0]           err_code,
  output logic                 busy,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    S_ENTER_A = 3'd0,
    S_ENTER_B = 3'd1,
    S_START   = 3'd2,
    S_WAIT    = 3'd3,
    S_RESULT  = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  state_t               state;
  state_t               next_state;
  logic                 prev_next;
  logic                 prev_equals;
  logic                 prev_clear;
  logic                 next_edge;
  logic                 equals_edge;
  logic                 clear_edge;
  logic                 res_negative;
  logic [RES_WIDTH-1:0] magnitude;
  logic                 out_of_range;
  logic                 timed_out;
  logic                 latch_result;
  logic [1:0]           next_err;
  logic [1:0]           next_display;

  assign state_dbg = state;

  // Rising-edge detect on the synchronized button levels.
  always_comb begin
    next_edge   = btn_next & ~prev_next;
    equals_edge = btn_equals & ~prev_equals;
    clear_edge  = btn_clear & ~prev_clear;
  end

  // Magnitude and range check of the ALU result at full width.
  // The most negative value negates to itself and lands out of range.
  always_comb begin
    res_negative = alu_result[RES_WIDTH-1];
    magnitude    = res_negative ? (~alu_result + RES_WIDTH'(1)) : alu_result;
    out_of_range = magnitude > RES_WIDTH'(MAX_VALUE);
  end

`ifdef CALC_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt;

  // Watchdog: held at zero outside WAIT, counts WAIT cycles.
  always_ff @(posedge clk or negedge rst_ext) begin
    if (!rst_ext) begin
      wd_cnt <= '0;
    end else if (state != S_WAIT) begin
      wd_cnt <= '0;
    end else if (wd_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end

  assign timed_out = (state == S_WAIT) && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timed_out = 1'b0;
`endif

  // Next-state and error decode.
  // Priority is clear > equals > next; alu_done beats a same-cycle timeout.
  always_comb begin
    next_state   = state;
    next_err     = err_code;
    latch_result = 1'b0;
    if (clear_edge) begin
      next_state = S_ENTER_A;
      next_err   = 2'b00;
    end else begin
      case (state)
        S_ENTER_A: if (next_edge) next_state = S_ENTER_B;
        S_ENTER_B: begin
          if (equals_edge)    next_state = S_START;
          else if (next_edge) next_state = S_ENTER_A;
        end
        S_START:   next_state = S_WAIT;
        S_WAIT: begin
          if (alu_done) begin
            if (alu_error) begin
              next_state = S_ERROR;
              next_err   = 2'b01;
            end else if (out_of_range) begin
              next_state = S_ERROR;
              next_err   = 2'b10;
            end else begin
              next_state   = S_RESULT;
              latch_result = 1'b1;
            end
          end else if (timed_out) begin
            next_state = S_ERROR;
            next_err   = 2'b11;
          end
        end
        S_RESULT: begin
          if (equals_edge)    next_state = S_START;
          else if (next_edge) next_state = S_ENTER_A;
        end
        S_ERROR:   next_state = S_ERROR;
        default:   next_state = S_ENTER_A;
      endcase
    end
  end

  // Display source for the state being entered.
  always_comb begin
    case (next_state)
      S_ENTER_A: next_display = 2'b00;
      S_RESULT:  next_display = 2'b10;
      S_ERROR:   next_display = 2'b11;
      default:   next_display = 2'b01;
    endcase
  end

  // FSM state, edge history and registered outputs.
  // Outputs are registered to match the state being entered.
  always_ff @(posedge clk or negedge rst_ext) begin
    if (!rst_ext) begin
      state               <= S_ENTER_A;
      prev_next           <= 1'b1;
      prev_equals         <= 1'b1;
      prev_clear          <= 1'b1;
      write_number_select <= 1'b0;
      slider_enable       <= 1'b0;
      clear_numbers       <= 1'b0;
      alu_start           <= 1'b0;
      alu_op              <= 2'b00;
      result              <= '0;
      result_neg          <= 1'b0;
      display_select      <= 2'b00;
      err_code            <= 2'b00;
      busy                <= 1'b0;
    end else begin
      state               <= next_state;
      prev_next           <= btn_next;
      prev_equals         <= btn_equals;
      prev_clear          <= btn_clear;
      err_code            <= next_err;
      clear_numbers       <= clear_edge;
      alu_start           <= (next_state == S_START);
      slider_enable       <= (next_state == S_ENTER_A) || (next_state == S_ENTER_B);
      write_number_select <= (next_state == S_ENTER_B);
      busy                <= (next_state == S_START) || (next_state == S_WAIT);
      display_select      <= next_display;
      if (next_state == S_START) alu_op <= op_sel;
      if (clear_edge) begin
        result     <= '0;
        result_neg <= 1'b0;
      end else if (latch_result) begin
        result     <= magnitude[WIDTH-1:0];
        result_neg <= res_negative;
      end
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed scenarios plus randomized computations.
// Expected display/error/result tuples go through a scoreboard queue.
module tb_calc_sequencer;

  localparam int W = 19;  // {display_select, err_code, result_neg, result}

  logic        clk;
  logic        rst_ext;
  logic        btn_next;
  logic        btn_equals;
  logic        btn_clear;
  logic [1:0]  op_sel;
  logic        alu_done;
  logic        alu_error;
  logic [27:0] alu_result;
  logic        write_number_select;
  logic        slider_enable;
  logic        clear_numbers;
  logic        alu_start;
  logic [1:0]  alu_op;
  logic [13:0] result;
  logic        result_neg;
  logic [1:0]  display_select;
  logic [1:0]  err_code;
  logic        busy;
  logic [2:0]  state_dbg;

  int checks;
  int failures;
  logic [W-1:0] exp_q[$];
  logic        model_neg;
  logic [13:0] model_res;

  calc_sequencer #(
    .WIDTH(14), .MAX_VALUE(9999), .RES_WIDTH(28), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_ext(rst_ext), .btn_next(btn_next), .btn_equals(btn_equals),
    .btn_clear(btn_clear), .op_sel(op_sel), .alu_done(alu_done),
    .alu_error(alu_error), .alu_result(alu_result),
    .write_number_select(write_number_select), .slider_enable(slider_enable),
    .clear_numbers(clear_numbers), .alu_start(alu_start), .alu_op(alu_op),
    .result(result), .result_neg(result_neg), .display_select(display_select),
    .err_code(err_code), .busy(busy), .state_dbg(state_dbg)
  );

  // Clock and global time limit.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: bench still running at %0t, required finish earlier", $time);
    $fatal(1, "bench time limit");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic press_next();
    btn_next = 1'b1;
    cycle();
    btn_next = 1'b0;
    cycle();
  endtask

  task automatic do_clear();
    btn_clear = 1'b1;
    cycle();
    btn_clear = 1'b0;
    cycle();
    model_neg = 1'b0;
    model_res = '0;
  endtask

  // Launch from ENTER_B or RESULT and return one ALU answer.
  task automatic compute(input logic [1:0] op, input int value, input logic err);
    int starts;
    int mag;
    logic [W-1:0] exp_v;
    logic [W-1:0] got;
    op_sel     = op;
    btn_equals = 1'b1;
    cycle();
    checks++;
    if (state_dbg !== 3'd2 || alu_start !== 1'b1 || alu_op !== op || busy !== 1'b1)
      begin
        failures++;
        $display("FAIL launch: state=%0d start=%b op=%b busy=%b, required state=2 start=1 op=%b busy=1",
                 state_dbg, alu_start, alu_op, busy, op);
      end
    btn_equals = 1'b0;
    starts = alu_start ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (alu_start) starts++;
    end
    checks++;
    if (starts != 1 || state_dbg !== 3'd3) begin
      failures++;
      $display("FAIL start_pulse: pulses=%0d state=%0d, required pulses=1 state=3", starts, state_dbg);
    end
    mag = (value < 0) ? -value : value;
    if (err) exp_v = {2'b11, 2'b01, model_neg, model_res};
    else if (mag > 9999) exp_v = {2'b11, 2'b10, model_neg, model_res};
    else begin
      model_neg = (value < 0);
      model_res = mag[13:0];
      exp_v = {2'b10, 2'b00, model_neg, model_res};
    end
    exp_q.push_back(exp_v);
    alu_result = 28'(value);
    alu_error  = err;
    alu_done   = 1'b1;
    cycle();
    alu_done  = 1'b0;
    alu_error = 1'b0;
    got   = {display_select, err_code, result_neg, result};
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v || busy !== 1'b0) begin
      failures++;
      $display("FAIL result(value=%0d err=%b): disp/err/neg/res=%h busy=%b, required %h busy=0",
               value, err, got, busy, exp_v);
    end
  endtask

  task automatic test_reset();
    rst_ext = 1'b0;
    btn_next = 1'b1;
    btn_equals = 1'b0;
    btn_clear = 1'b0;
    op_sel = 2'b00;
    alu_done = 1'b0;
    alu_error = 1'b0;
    alu_result = '0;
    model_neg = 1'b0;
    model_res = '0;
    #23;
    checks++;
    if (state_dbg !== 3'd0 || slider_enable !== 1'b0 || write_number_select !== 1'b0 ||
        clear_numbers !== 1'b0 || alu_start !== 1'b0 || alu_op !== 2'b00 ||
        result !== 14'd0 || result_neg !== 1'b0 || display_select !== 2'b00 ||
        err_code !== 2'b00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: state=%0d slid=%b wsel=%b clr=%b start=%b res=%0d disp=%b err=%b busy=%b, required all zero",
               state_dbg, slider_enable, write_number_select, clear_numbers, alu_start,
               result, display_select, err_code, busy);
    end
    @(negedge clk);
    rst_ext = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    checks++;
    if (state_dbg !== 3'd0 || slider_enable !== 1'b1 || write_number_select !== 1'b0) begin
      failures++;
      $display("FAIL held_next: state=%0d slid=%b wsel=%b, required state=0 slid=1 wsel=0",
               state_dbg, slider_enable, write_number_select);
    end
    btn_next = 1'b0;
    cycle();
    btn_next = 1'b1;
    cycle();
    checks++;
    if (state_dbg !== 3'd1 || write_number_select !== 1'b1 || display_select !== 2'b01) begin
      failures++;
      $display("FAIL enter_b: state=%0d wsel=%b disp=%b, required state=1 wsel=1 disp=01",
               state_dbg, write_number_select, display_select);
    end
    btn_next = 1'b0;
    cycle();
  endtask

  task automatic test_result_path();
    compute(2'b10, 1234, 1'b0);
    compute(2'b01, -25, 1'b0);
    compute(2'b00, 9999, 1'b0);
    compute(2'b01, -9999, 1'b0);
    press_next();
    checks++;
    if (state_dbg !== 3'd0 || display_select !== 2'b00) begin
      failures++;
      $display("FAIL result_next: state=%0d disp=%b, required state=0 disp=00", state_dbg, display_select);
    end
    press_next();
    compute(2'b11, 10000, 1'b0);
  endtask

  task automatic test_error_hold();
    int starts;
    starts = 0;
    btn_next = 1'b1;
    cycle();
    btn_next = 1'b0;
    btn_equals = 1'b1;
    cycle();
    if (alu_start) starts++;
    btn_equals = 1'b0;
    cycle();
    if (alu_start) starts++;
    checks++;
    if (state_dbg !== 3'd5 || starts != 0 || err_code !== 2'b10) begin
      failures++;
      $display("FAIL error_hold: state=%0d starts=%0d err=%b, required state=5 starts=0 err=10",
               state_dbg, starts, err_code);
    end
    btn_clear = 1'b1;
    cycle();
    checks++;
    if (state_dbg !== 3'd0 || clear_numbers !== 1'b1 || err_code !== 2'b00 ||
        result !== 14'd0 || result_neg !== 1'b0) begin
      failures++;
      $display("FAIL clear_exit: state=%0d clr=%b err=%b res=%0d neg=%b, required 0 1 00 0 0",
               state_dbg, clear_numbers, err_code, result, result_neg);
    end
    cycle();
    checks++;
    if (clear_numbers !== 1'b0) begin
      failures++;
      $display("FAIL clear_pulse_len: clr=%b, required 0", clear_numbers);
    end
    btn_clear = 1'b0;
    cycle();
    model_neg = 1'b0;
    model_res = '0;
    btn_equals = 1'b1;
    cycle();
    btn_equals = 1'b0;
    checks++;
    if (state_dbg !== 3'd0 || alu_start !== 1'b0) begin
      failures++;
      $display("FAIL equals_in_a: state=%0d start=%b, required state=0 start=0", state_dbg, alu_start);
    end
    cycle();
    press_next();
    compute(2'b11, 7, 1'b1);
    do_clear();
  endtask

  task automatic test_clear_equals();
    press_next();
    btn_clear = 1'b1;
    btn_equals = 1'b1;
    cycle();
    checks++;
    if (state_dbg !== 3'd0 || alu_start !== 1'b0 || clear_numbers !== 1'b1) begin
      failures++;
      $display("FAIL clear_vs_equals: state=%0d start=%b clr=%b, required 0 0 1",
               state_dbg, alu_start, clear_numbers);
    end
    btn_clear = 1'b0;
    btn_equals = 1'b0;
    cycle();
    checks++;
    if (state_dbg !== 3'd0 || alu_start !== 1'b0) begin
      failures++;
      $display("FAIL clear_vs_equals_after: state=%0d start=%b, required 0 0", state_dbg, alu_start);
    end
  endtask

  task automatic test_abort();
    press_next();
    btn_equals = 1'b1;
    cycle();
    btn_equals = 1'b0;
    cycle();
    checks++;
    if (state_dbg !== 3'd3 || busy !== 1'b1 || display_select !== 2'b01) begin
      failures++;
      $display("FAIL wait_state: state=%0d busy=%b disp=%b, required 3 1 01", state_dbg, busy, display_select);
    end
    btn_clear = 1'b1;
    cycle();
    btn_clear = 1'b0;
    cycle();
    alu_result = 28'd5;
    alu_done = 1'b1;
    cycle();
    alu_done = 1'b0;
    cycle();
    checks++;
    if (state_dbg !== 3'd0 || result !== 14'd0 || display_select !== 2'b00 ||
        err_code !== 2'b00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stray_done: state=%0d res=%0d disp=%b err=%b busy=%b, required 0 0 00 00 0",
               state_dbg, result, display_select, err_code, busy);
    end
  endtask

  task automatic test_timeout();
    int waits;
    press_next();
    btn_equals = 1'b1;
    cycle();
    btn_equals = 1'b0;
    waits = 0;
`ifdef CALC_SEQ_TIMEOUT_EN
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (state_dbg == 3'd3) waits++;
      else break;
    end
    checks++;
    if (waits != 8 || state_dbg !== 3'd5 || err_code !== 2'b11 || display_select !== 2'b11) begin
      failures++;
      $display("FAIL timeout: waits=%0d state=%0d err=%b disp=%b, required 8 5 11 11",
               waits, state_dbg, err_code, display_select);
    end
`else
    for (int i = 0; i < 2000; i++) begin
      cycle();
      if (state_dbg == 3'd3) waits++;
    end
    checks++;
    if (waits != 2000 || state_dbg !== 3'd3 || busy !== 1'b1 || err_code !== 2'b00) begin
      failures++;
      $display("FAIL no_timeout: waits=%0d state=%0d busy=%b err=%b, required 2000 3 1 00",
               waits, state_dbg, busy, err_code);
    end
`endif
    do_clear();
  endtask

  task automatic test_random();
    int value;
    logic err;
    logic [1:0] op;
    for (int n = 0; n < 8; n++) begin
      press_next();
      value = int'($urandom_range(0, 24000)) - 12000;
      err   = ($urandom_range(0, 4) == 0);
      op    = 2'($urandom_range(0, 3));
      compute(op, value, err);
      do_clear();
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_result_path();
    test_error_hold();
    test_clear_equals();
    test_abort();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
